// File: rtl/uart_boot_loader.sv
// UART boot loader: parses a 0x11 0x55 LEN16 framed byte stream and turns the
// payload into 32-bit little-endian SDRAM write requests while holding the CPU.
module uart_boot_loader #(
  parameter logic [24:0] BASE_ADDR = 25'h0000040,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axis_rx_tvalid,
  output logic        s_axis_rx_tready,
  input  logic [7:0]  s_axis_rx_tdata,
  output logic        m_axis_sdram_req_tvalid,
  input  logic        m_axis_sdram_req_tready,
  output logic [63:0] m_axis_sdram_req_tdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {
    SYNC1  = 3'd0,
    SYNC2  = 3'd1,
    LEN_HI = 3'd2,
    LEN_LO = 3'd3,
    DATA   = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] pay_idx_q, pay_idx_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [15:0] words_q, words_d;
  logic [31:0] pack_q, pack_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] idle_q, idle_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        byte_ok;
  logic        idle_run;
  logic        timeout_hit;
  logic [1:0]  lane;
  logic [24:0] word_addr;

  // The receive side is closed while a request is outstanding so the UART
  // source stalls instead of dropping bytes.
  assign s_axis_rx_tready = !reset && (state_q != WRITE);
  assign byte_ok          = s_axis_rx_tvalid && s_axis_rx_tready;
  assign lane             = pay_idx_q[1:0];
  assign idle_run         = (state_q == SYNC2) || (state_q == LEN_HI) ||
                            (state_q == LEN_LO) || (state_q == DATA);
  assign timeout_hit      = idle_run && !byte_ok && (idle_q >= TIMEOUT_M1);
  assign word_addr        = BASE_ADDR + {9'd0, word_idx_q};

  assign m_axis_sdram_req_tvalid = (state_q == WRITE);
  assign m_axis_sdram_req_tdata  = {2'b00, 1'b1, mask_q, word_addr, pack_q};
  assign cpu_hold                = cpu_hold_q;
  assign done                    = done_q;
  assign error                   = error_q;
  assign words_written           = words_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pay_idx_d  = pay_idx_q;
    word_idx_d = word_idx_q;
    words_d    = words_q;
    pack_d     = pack_q;
    mask_d     = mask_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;
    idle_d     = (byte_ok || !idle_run) ? 32'd0 : idle_q + 32'd1;

    unique case (state_q)
      SYNC1, DONE: begin
        if (byte_ok && s_axis_rx_tdata == 8'h11) state_d = SYNC2;
      end
      SYNC2: begin
        if (byte_ok) begin
          if (s_axis_rx_tdata == 8'h55) begin
            state_d    = LEN_HI;
            done_d     = 1'b0;
            error_d    = 1'b0;
            words_d    = 16'd0;
            cpu_hold_d = 1'b1;
          end else if (s_axis_rx_tdata != 8'h11) begin
            state_d = SYNC1;
          end
        end
      end
      LEN_HI: begin
        if (byte_ok) begin
          len_d[15:8] = s_axis_rx_tdata;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (byte_ok) begin
          len_d[7:0] = s_axis_rx_tdata;
          pay_idx_d  = 16'd0;
          word_idx_d = 16'd0;
          pack_d     = 32'd0;
          mask_d     = 4'd0;
          if ({len_q[15:8], s_axis_rx_tdata} == 16'd0) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (byte_ok) begin
          pack_d[{lane, 3'b000} +: 8] = s_axis_rx_tdata;
          mask_d[lane]                = 1'b1;
          pay_idx_d                   = pay_idx_q + 16'd1;
          if (lane == 2'd3 || pay_idx_q == len_q - 16'd1) state_d = WRITE;
        end
      end
      WRITE: begin
        if (m_axis_sdram_req_tready) begin
          words_d    = words_q + 16'd1;
          word_idx_d = word_idx_q + 16'd1;
          pack_d     = 32'd0;
          mask_d     = 4'd0;
          // pay_idx already counts every byte packed so far
          if (pay_idx_q == len_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end
      default: state_d = SYNC1;
    endcase

    if (timeout_hit) begin
      state_d = SYNC1;
      error_d = 1'b1;
      pack_d  = 32'd0;
      mask_d  = 4'd0;
      idle_d  = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SYNC1;
      len_q      <= 16'd0;
      pay_idx_q  <= 16'd0;
      word_idx_q <= 16'd0;
      words_q    <= 16'd0;
      pack_q     <= 32'd0;
      mask_q     <= 4'd0;
      idle_q     <= 32'd0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pay_idx_q  <= pay_idx_d;
      word_idx_q <= word_idx_d;
      words_q    <= words_d;
      pack_q     <= pack_d;
      mask_q     <= mask_d;
      idle_q     <= idle_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table of frame shapes, hand-written
// corner sequences and randomized frames checked against a payload-level model.
module tb_uart_boot_loader;
  localparam int          TMO  = 100;
  localparam logic [24:0] BASE = 25'h0000040;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  rx_data = 8'd0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic        cpu_hold, done, error;
  logic [15:0] words_written;

  always #5 clk = ~clk;

  uart_boot_loader #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .s_axis_rx_tvalid        (rx_valid),
    .s_axis_rx_tready        (rx_ready),
    .s_axis_rx_tdata         (rx_data),
    .m_axis_sdram_req_tvalid (m_valid),
    .m_axis_sdram_req_tready (m_ready),
    .m_axis_sdram_req_tdata  (m_data),
    .cpu_hold                (cpu_hold),
    .done                    (done),
    .error                   (error),
    .words_written           (words_written)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic sink_hold = 1'b0;
  logic sink_rand = 1'b0;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    int         len;
    bit         rand_ready;
    int         exp_words;
    logic [3:0] exp_last_mask;
  } vec_t;
  vec_t vecs[8];

  // SDRAM side: always ready, randomly ready, or held off
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sink_hold)      m_ready = 1'b0;
      else if (sink_rand) m_ready = 1'($urandom_range(0, 1));
      else                m_ready = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!reset && m_valid && m_ready) got_q.push_back(m_data);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Expected requests straight from the frame rules: word w holds bytes 4w..4w+3
  task automatic model_frame(input byte_q_t pay);
    int n;
    logic [31:0] d;
    logic [3:0]  m;
    n = pay.size();
    for (int w = 0; w < (n + 3) / 4; w++) begin
      d = 32'd0;
      m = 4'd0;
      for (int l = 0; l < 4; l++) begin
        if (w * 4 + l < n) begin
          d[l*8 +: 8] = pay[w*4+l];
          m[l] = 1'b1;
        end
      end
      exp_q.push_back({2'b00, 1'b1, m, 25'(BASE + 25'(w)), d});
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready) begin
      n++;
      if (n > 400) begin
        total++;
        bad++;
        $display("FAIL send_byte: byte 0x%0h got no tready within 400 cycles", b);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t pay);
    logic [15:0] len;
    len = 16'(pay.size());
    send_byte(8'h11);
    send_byte(8'h55);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    foreach (pay[i]) send_byte(pay[i]);
  endtask

  task automatic rand_payload(input int len, output byte_q_t pay);
    pay = {};
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic compare_reqs(input string name);
    check({name, "_req_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({name, "_req"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_backpressure();
    byte_q_t pay;
    rand_payload(8, pay);
    model_frame(pay);
    sink_hold = 1'b1;
    fork
      send_frame(pay);
      begin
        int n, unstable, rdy_hi, src_idle;
        logic [63:0] first;
        n = 0; unstable = 0; rdy_hi = 0; src_idle = 0;
        while (!m_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("bp_valid_seen", 64'(m_valid), 64'd1);
        first = m_data;
        repeat (50) begin
          @(negedge clk);
          if (m_data !== first || !m_valid) unstable++;
          if (rx_ready) rdy_hi++;
          if (!rx_valid) src_idle++;
        end
        check("bp_tdata_stable", 64'(unstable), 64'd0);
        check("bp_rx_tready_low", 64'(rdy_hi), 64'd0);
        check("bp_source_stalled", 64'(src_idle), 64'd0);
        sink_hold = 1'b0;
      end
    join
    wait_done("bp");
    check("bp_words", 64'(words_written), 64'd2);
    compare_reqs("bp");
  endtask

  task automatic test_timeout();
    byte_q_t pay;
    send_byte(8'h11); send_byte(8'h55); send_byte(8'h00);
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
    repeat (90) @(negedge clk);
    check("tmo_error_early", 64'(error), 64'd0);
    repeat (15) @(negedge clk);
    check("tmo_error_set", 64'(error), 64'd1);
    check("tmo_cpu_hold", 64'(cpu_hold), 64'd1);
    check("tmo_done", 64'(done), 64'd0);
    check("tmo_no_req", 64'(got_q.size()), 64'd0);
    got_q.delete();
    rand_payload(4, pay);
    model_frame(pay);
    send_frame(pay);
    wait_done("tmo_reload");
    check("tmo_error_cleared", 64'(error), 64'd0);
    compare_reqs("tmo_reload");
  endtask

  task automatic test_reset_in_write();
    byte_q_t pay;
    rand_payload(8, pay);
    sink_hold = 1'b1;
    send_byte(8'h11); send_byte(8'h55); send_byte(8'h00); send_byte(8'h08);
    for (int i = 0; i < 4; i++) send_byte(pay[i]);
    @(negedge clk);
    check("rst_wr_valid_before", 64'(m_valid), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wr_valid_after", 64'(m_valid), 64'd0);
    check("rst_wr_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_wr_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_wr_words", 64'(words_written), 64'd0);
    reset = 1'b0;
    sink_hold = 1'b0;
    got_q.delete();
    model_frame(pay);
    send_frame(pay);
    wait_done("rst_reload");
    check("rst_reload_words", 64'(words_written), 64'd2);
    compare_reqs("rst_reload");
  endtask

  initial begin
    byte_q_t pay;
    int len, ng;
    logic [63:0] last;

    vecs[0] = '{4,  1'b0, 1, 4'hF};
    vecs[1] = '{6,  1'b0, 2, 4'h3};
    vecs[2] = '{1,  1'b1, 1, 4'h1};
    vecs[3] = '{3,  1'b1, 1, 4'h7};
    vecs[4] = '{8,  1'b1, 2, 4'hF};
    vecs[5] = '{13, 1'b0, 4, 4'h1};
    vecs[6] = '{0,  1'b0, 0, 4'h0};
    vecs[7] = '{2,  1'b1, 1, 4'h3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", 64'(rx_ready), 64'd1);

    // Reference frames with fixed, hand-derived request words
    pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp_q.push_back(64'h3E00_0040_DDCC_BBAA);
    send_frame(pay);
    wait_done("f4");
    check("f4_cpu_hold", 64'(cpu_hold), 64'd0);
    check("f4_words", 64'(words_written), 64'd1);
    compare_reqs("f4");

    pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    exp_q.push_back(64'h3E00_0040_0403_0201);
    exp_q.push_back(64'h2600_0041_0000_0605);
    send_frame(pay);
    wait_done("f6");
    compare_reqs("f6");

    send_byte(8'h00); send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h00);
    wait_done("len0");
    check("len0_words", 64'(words_written), 64'd0);
    check("len0_cpu_hold", 64'(cpu_hold), 64'd0);
    compare_reqs("len0");

    for (int v = 0; v < 8; v++) begin
      sink_rand = vecs[v].rand_ready;
      rand_payload(vecs[v].len, pay);
      model_frame(pay);
      send_frame(pay);
      wait_done($sformatf("vec%0d", v));
      check($sformatf("vec%0d_words", v), 64'(words_written), 64'(vecs[v].exp_words));
      if (got_q.size() > 0) begin
        last = got_q[got_q.size()-1];
        check($sformatf("vec%0d_last_mask", v), 64'(last[60:57]), 64'(vecs[v].exp_last_mask));
      end
      compare_reqs($sformatf("vec%0d", v));
      $display("vector %0d: len=%0d words_written=%0d", v, vecs[v].len, words_written);
    end
    sink_rand = 1'b0;

    test_backpressure();
    test_timeout();
    test_reset_in_write();

    sink_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      ng = $urandom_range(0, 3);
      for (int g = 0; g < ng; g++) send_byte(8'($urandom_range(0, 15)) == 8'h1 ? 8'h22 : 8'($urandom_range(0, 15)));
      len = $urandom_range(1, 23);
      rand_payload(len, pay);
      model_frame(pay);
      send_frame(pay);
      wait_done($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_words", r), 64'(words_written), 64'((len + 3) / 4));
      compare_reqs($sformatf("rnd%0d", r));
      $display("random frame %0d: len=%0d garbage=%0d", r, len, ng);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800_000;
    bad++;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameter BASE_ADDR, default 25'h0000040, SHALL give the SDRAM word address of the first loaded word (byte address 0x100).
REQ-002 Parameter TIMEOUT, default 1_000_000, SHALL give the maximum clk cycles allowed between bytes inside a frame.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 s_axis_rx_tvalid / s_axis_rx_tready / s_axis_rx_tdata  in / out / in  1/1/8  SHALL carry the UART receive byte stream (AXI-Stream).
REQ-006 m_axis_sdram_req_tvalid / m_axis_sdram_req_tready / m_axis_sdram_req_tdata  out / in / out  1/1/64  SHALL carry SDRAM write requests.
REQ-007 cpu_hold  out  1  SHALL hold the CPU in reset while high.
REQ-008 done  out  1  SHALL be high when a complete image has been written.
REQ-009 error  out  1  SHALL flag an aborted frame (timeout).
REQ-010 words_written  out  16  SHALL count the SDRAM write requests accepted in the current frame.

Function
REQ-011 Frame format SHALL be 0x11, 0x55, LEN[15:8], LEN[7:0], then LEN payload bytes.
REQ-012 States SHALL be SYNC1, SYNC2, LEN_HI, LEN_LO, DATA, WRITE, DONE.
REQ-013 SYNC1: byte 0x11 -> SYNC2; any other byte is dropped and the state is unchanged.
REQ-014 SYNC2: byte 0x55 -> LEN_HI; byte 0x11 -> stay in SYNC2; any other byte -> SYNC1.
REQ-015 LEN_HI latches LEN[15:8]; LEN_LO latches LEN[7:0]; from LEN_LO, LEN=0 -> DONE, else -> DATA.
REQ-016 DATA packs bytes little-endian into a 32-bit word: the first byte goes to bits [7:0], and byte lane = payload index mod 4.
REQ-017 On the 4th lane, or on the last payload byte, the state SHALL become WRITE with tvalid=1 on the next cycle.
REQ-018 Request tdata SHALL be: [31:0] data; [56:32] word address = BASE_ADDR + word index; [60:57] byte mask (bit n = lane n valid); [61]=1 (write); [63:62]=0.
REQ-019 A final partial word SHALL carry only its valid lanes in the mask; invalid lanes are 0 in data.
REQ-020 WRITE SHALL hold tdata stable while tvalid && !tready.
REQ-021 On tready, words_written SHALL increment, then: more payload -> DATA, else -> DONE.
REQ-022 s_axis_rx_tready SHALL be 1 in SYNC1, SYNC2, LEN_HI, LEN_LO and DATA, and 0 in WRITE (no byte lost under backpressure).
REQ-023 In DONE, s_axis_rx_tready=1 and bytes SHALL be parsed as in SYNC1; a new 0x11 0x55 header starts a reload.
REQ-024 On header acceptance (entering LEN_HI), done, error and words_written SHALL clear and cpu_hold SHALL be set.
REQ-025 Entering DONE SHALL set done=1 and cpu_hold=0 on the next cycle.
REQ-026 An idle counter SHALL reset on every accepted byte and run in SYNC2, LEN_HI, LEN_LO and DATA.
REQ-027 An idle count reaching TIMEOUT SHALL set error=1 (sticky), discard any partial word and go to SYNC1; cpu_hold stays 1.
REQ-028 WRITE SHALL never time out; it waits indefinitely for tready.
REQ-029 Payload index and word index SHALL be 16-bit; LEN=65535 SHALL be supported (16384 words, last mask 4'b0111).
REQ-030 The address add SHALL wrap modulo 2^25.

Reset
REQ-031 reset SHALL force: state SYNC1, cpu_hold=1, done=0, error=0, words_written=0, m_axis_sdram_req_tvalid=0, s_axis_rx_tready=0 during reset, packing register and counters 0.
REQ-032 Reset asserted mid-frame or mid-WRITE SHALL abandon the pending request on the next edge.

Verification
REQ-033 Stream 11 55 00 04 AA BB CC DD, tready=1 -> one request, data 0xDDCCBBAA, addr 0x40, mask 4'hF; done=1; cpu_hold=0; words_written=1.
REQ-034 Stream 11 55 00 06 01..06 -> requests {0x04030201, addr 0x40, mask F} then {0x00000605, addr 0x41, mask 4'h3}.
REQ-035 Bytes 00 11 11 55 00 00 -> done=1 with no requests issued.
REQ-036 Hold tready=0 for 50 cycles during WRITE -> tdata stable, rx tready=0 and the source stalls; no data is lost.
REQ-037 TIMEOUT=100: send 11 55 00 08 01 02, then go idle -> error=1 after 100 cycles; no request issued; a subsequent valid frame clears error.
REQ-038 Assert reset during WRITE of a 2-word frame -> tvalid=0 and cpu_hold=1 next cycle; a resent frame loads correctly.
